// File: rtl/puf_eval_controller.sv
// Fires the PUF NUM_EVALS times per challenge and majority-votes each synchronised response bit.
// Result valid NUM_EVALS*(CLEAR_CYCLES+SETTLE_CYCLES+1)+1 cycles after acceptance; held until resp_ready.
module puf_eval_controller #(
  parameter int CHALLENGE_WIDTH = 64,
  parameter int RESPONSE_WIDTH  = 6,
  parameter int NUM_EVALS       = 15,
  parameter int CLEAR_CYCLES    = 2,
  parameter int SETTLE_CYCLES   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CHALLENGE_WIDTH-1:0] challenge_in,
  output logic                       busy,
  output logic [CHALLENGE_WIDTH-1:0] challenge_out,
  output logic                       puf_trigger,
  output logic                       puf_clear,
  input  logic [RESPONSE_WIDTH-1:0]  raw_response,
  input  logic                       xor_response,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [RESPONSE_WIDTH-1:0]  maj_response,
  output logic                       maj_xor,
  output logic [RESPONSE_WIDTH-1:0]  unstable
);

  localparam int CNT_W  = $clog2(NUM_EVALS + 1);
  localparam int IDX_W  = (NUM_EVALS > 1) ? $clog2(NUM_EVALS) : 1;
  localparam int PH_MAX = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [CNT_W-1:0] MAJ_TH    = CNT_W'((NUM_EVALS + 1) / 2);
  localparam logic [CNT_W-1:0] ALL_ONES  = CNT_W'(NUM_EVALS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_EVALS - 1);
  localparam logic [PH_W-1:0]  CLR_LAST  = PH_W'(CLEAR_CYCLES - 1);
  localparam logic [PH_W-1:0]  SET_LAST  = PH_W'(SETTLE_CYCLES - 1);

  if ((NUM_EVALS < 1) || (NUM_EVALS % 2 == 0)) begin : g_bad_num_evals
    $error("NUM_EVALS must be odd and >= 1");
  end
  if (CLEAR_CYCLES < 1) begin : g_bad_clear
    $error("CLEAR_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 3");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FIRE,
    SAMPLE,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [PH_W-1:0]                      phase_cnt;
  logic [IDX_W-1:0]                     eval_idx;
  logic [RESPONSE_WIDTH-1:0][CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0]                     xor_cnt;
  logic [RESPONSE_WIDTH-1:0]            raw_meta, raw_sync;
  logic                                 xor_meta, xor_sync;
  logic [RESPONSE_WIDTH-1:0]            maj_nxt, unst_nxt;
  logic                                 maj_xor_nxt, unst_xor_nxt;
  logic                                 accept, handshake;

  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) && start;
  assign handshake = (state == DONE) && resp_valid && resp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Trigger/clear decode straight from the state register so reset drops them without a clock.
  always_comb begin
    state_nxt   = state;
    puf_trigger = 1'b0;
    puf_clear   = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = CLEAR;
      CLEAR: begin
        puf_clear = 1'b1;
        if (phase_cnt == CLR_LAST) state_nxt = FIRE;
      end
      FIRE: begin
        puf_trigger = 1'b1;
        if (phase_cnt == SET_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        puf_trigger = 1'b1;
        state_nxt   = (eval_idx == LAST_IDX) ? DONE : CLEAR;
      end
      DONE:   if (resp_valid && resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    maj_nxt  = '0;
    unst_nxt = '0;
    for (int i = 0; i < RESPONSE_WIDTH; i++) begin
      maj_nxt[i]  = (ones_cnt[i] >= MAJ_TH);
      unst_nxt[i] = (ones_cnt[i] != '0) && (ones_cnt[i] != ALL_ONES);
    end
    maj_xor_nxt  = (xor_cnt >= MAJ_TH);
    unst_xor_nxt = (xor_cnt != '0) && (xor_cnt != ALL_ONES);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_meta <= '0;
      raw_sync <= '0;
      xor_meta <= 1'b0;
      xor_sync <= 1'b0;
    end else begin
      raw_meta <= raw_response;
      raw_sync <= raw_meta;
      xor_meta <= xor_response;
      xor_sync <= xor_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt     <= '0;
      eval_idx      <= '0;
      ones_cnt      <= '0;
      xor_cnt       <= '0;
      challenge_out <= '0;
      maj_response  <= '0;
      maj_xor       <= 1'b0;
      unstable      <= '0;
      resp_valid    <= 1'b0;
    end else begin
      if (((state == CLEAR) || (state == FIRE)) && (state_nxt == state))
        phase_cnt <= phase_cnt + 1'b1;
      else
        phase_cnt <= '0;

      if (accept) begin
        challenge_out <= challenge_in;
        eval_idx      <= '0;
        ones_cnt      <= '0;
        xor_cnt       <= '0;
      end

      if (state == SAMPLE) begin
        for (int i = 0; i < RESPONSE_WIDTH; i++)
          ones_cnt[i] <= ones_cnt[i] + CNT_W'(raw_sync[i]);
        xor_cnt <= xor_cnt + CNT_W'(xor_sync);
        if (eval_idx != LAST_IDX) eval_idx <= eval_idx + 1'b1;
      end

      // The last sample lands on the DONE entry edge, so results are registered one cycle later.
      if ((state == DONE) && !resp_valid) begin
        maj_response <= maj_nxt;
        maj_xor      <= maj_xor_nxt;
        unstable     <= unst_nxt;
        resp_valid   <= 1'b1;
      end else if (handshake) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // The xor stream has no instability output; its flag is computed only for symmetry.
  logic unused_unst_xor;
  assign unused_unst_xor = unst_xor_nxt;

endmodule

// File: tb/tb_puf_eval_controller.sv
// Directed bench: behavioural PUF returns per-evaluation patterns; results checked against hand-computed values.
module tb_puf_eval_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] challenge_in;
  logic        busy;
  logic [63:0] challenge_out;
  logic        puf_trigger;
  logic        puf_clear;
  logic [5:0]  raw_response;
  logic        xor_response;
  logic        resp_valid;
  logic        resp_ready;
  logic [5:0]  maj_response;
  logic        maj_xor;
  logic [5:0]  unstable;

  int checks = 0;
  int failures = 0;

  int mode = 0;
  int eval_cnt = 0;
  int eval_base = 0;
  int e;

  puf_eval_controller dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .challenge_in  (challenge_in),
    .busy          (busy),
    .challenge_out (challenge_out),
    .puf_trigger   (puf_trigger),
    .puf_clear     (puf_clear),
    .raw_response  (raw_response),
    .xor_response  (xor_response),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .maj_response  (maj_response),
    .maj_xor       (maj_xor),
    .unstable      (unstable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each trigger rise starts a new evaluation; the response for that evaluation is set here.
  always @(posedge puf_trigger) begin
    e = eval_cnt - eval_base;
    case (mode)
      0: begin raw_response = 6'b101100; xor_response = 1'b1; end
      1: begin raw_response = {5'b0, (e % 2 == 0)}; xor_response = 1'b0; end
      2: begin raw_response = {(e < 7), 5'b0}; xor_response = (e < 8); end
      default: begin raw_response = 6'b010011; xor_response = 1'b0; end
    endcase
    eval_cnt = eval_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues start, then counts edges until resp_valid; optionally pokes start/challenge mid-run.
  task automatic run_request(input logic [63:0] ch, input int mode_i, input int poke_cycle,
                             output int lat, output bit chal_ok);
    mode         = mode_i;
    eval_base    = eval_cnt;
    challenge_in = ch;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat     = 0;
    chal_ok = 1'b1;
    while (!resp_valid && lat < 300) begin
      if (lat == poke_cycle) begin
        start        = 1'b1;
        challenge_in = ~ch;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (challenge_out !== ch) chal_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk({tag, "_valid_low"}, resp_valid, 0);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int  lat;
    bit  chal_ok;
    bit  hold_ok;
    reset        = 1'b0;
    start        = 1'b0;
    resp_ready   = 1'b0;
    challenge_in = '0;
    raw_response = '0;
    xor_response = 1'b0;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_trigger", puf_trigger, 0);
    chk("rst_clear", puf_clear, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_chal", challenge_out, 0);
    chk("rst_maj", maj_response, 0);
    chk("rst_maj_xor", maj_xor, 0);
    chk("rst_unstable", unstable, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Constant response, then hold the result with resp_ready low.
    run_request(64'hDEADBEEF_01234567, 0, -1, lat, chal_ok);
    chk("t1_latency", lat, 166);
    chk("t1_chal_stable", chal_ok, 1);
    chk("t1_evals", eval_cnt - eval_base, 15);
    chk("t1_maj", maj_response, 6'b101100);
    chk("t1_maj_xor", maj_xor, 1);
    chk("t1_unstable", unstable, 0);
    chk("t1_busy", busy, 1);
    chk("t1_trigger_done", puf_trigger, 0);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || busy !== 1'b1 || maj_response !== 6'b101100 ||
          maj_xor !== 1'b1 || unstable !== 6'b0 || challenge_out !== 64'hDEADBEEF_01234567)
        hold_ok = 1'b0;
    end
    start = 1'b0;
    chk("t1_hold_stable", hold_ok, 1);
    handshake("t1");

    // Alternating bit0, resp_ready high the whole run; start in DONE alongside ready is ignored.
    resp_ready = 1'b1;
    run_request(64'h0000_0000_0000_00A5, 1, -1, lat, chal_ok);
    chk("t2_latency", lat, 166);
    chk("t2_maj", maj_response, 6'b000001);
    chk("t2_unstable", unstable, 6'b000001);
    chk("t2_maj_xor", maj_xor, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    resp_ready = 1'b0;
    chk("t2_valid_low", resp_valid, 0);
    chk("t2_no_restart", busy, 0);
    @(posedge clk);
    #1;
    chk("t2_still_idle", busy, 0);

    // Bit5 high in exactly 7 of 15 evals; xor high in 8.
    run_request(64'h01234567_89ABCDEF, 2, -1, lat, chal_ok);
    chk("t3_latency", lat, 166);
    chk("t3_maj", maj_response, 6'b000000);
    chk("t3_unstable", unstable, 6'b100000);
    chk("t3_maj_xor", maj_xor, 1);
    handshake("t3");

    // start and challenge_in disturbed at cycle 50 of the run.
    run_request(64'hCAFEF00D_12345678, 0, 50, lat, chal_ok);
    chk("t4_latency", lat, 166);
    chk("t4_chal_stable", chal_ok, 1);
    chk("t4_evals", eval_cnt - eval_base, 15);
    chk("t4_maj", maj_response, 6'b101100);
    handshake("t4");
    repeat (3) @(posedge clk);
    #1;
    chk("t4_single_result", busy, 0);

    // Reset asserted during FIRE of evaluation 3.
    mode         = 0;
    eval_base    = eval_cnt;
    challenge_in = 64'hA5A5A5A5_5A5A5A5A;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    chk("t5_trigger_before", puf_trigger, 1);
    chk("t5_clear_before", puf_clear, 0);
    reset = 1'b0;
    #1;
    chk("t5_trigger_async", puf_trigger, 0);
    chk("t5_busy", busy, 0);
    chk("t5_valid", resp_valid, 0);
    chk("t5_chal", challenge_out, 0);
    chk("t5_maj", maj_response, 0);
    chk("t5_maj_xor", maj_xor, 0);
    chk("t5_unstable", unstable, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_idle_after", busy, 0);
    run_request(64'h11111111_22222222, 3, -1, lat, chal_ok);
    chk("t5_latency", lat, 166);
    chk("t5_evals", eval_cnt - eval_base, 15);
    chk("t5_maj", maj_response, 6'b010011);
    chk("t5_unstable", unstable, 6'b000000);
    chk("t5_maj_xor", maj_xor, 0);
    handshake("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/puf_eval_controller.md
Name: puf_eval_controller

Overview:
- Sequencing stage directly downstream of the PUF mapping block. It consumes that block's raw_response/xor_response and drives its trigger and reset.
- Per request: latches one challenge, fires the PUF NUM_EVALS times, majority-votes each response bit, flags unstable bits, and returns the result over a valid/ready handshake.
- Feeds the host-side SIRC handler.

Parameters:
- CHALLENGE_WIDTH, 64, challenge width driven to the mapping block.
- RESPONSE_WIDTH, 6, raw PUF response width.
- NUM_EVALS, 15, evaluations per challenge; odd and >=1. An even value is an elaboration error.
- CLEAR_CYCLES, 2, cycles puf_clear is held per evaluation; >=1.
- SETTLE_CYCLES, 8, cycles from trigger rise to sample; >=3, which covers the 2-flop synchroniser.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- challenge_in  in  CHALLENGE_WIDTH  challenge sampled on start acceptance.
- busy  out  1  high from acceptance until result handshake completes.
- challenge_out  out  CHALLENGE_WIDTH  latched challenge to mapping block; stable while busy.
- puf_trigger  out  1  trigger to mapping block.
- puf_clear  out  1  arbiter clear to mapping block reset input.
- raw_response  in  RESPONSE_WIDTH  asynchronous arbiter outputs.
- xor_response  in  1  asynchronous XOR-network output.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- maj_response  out  RESPONSE_WIDTH  per-bit majority.
- maj_xor  out  1  majority of sampled xor_response.
- unstable  out  RESPONSE_WIDTH  bit set if that bit disagreed across evaluations.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy, puf_trigger, puf_clear and resp_valid = 0.
  - challenge_out, maj_response, maj_xor, unstable = 0.
  - All counters and the synchroniser flops = 0.
  - Asserting reset mid-run aborts the run immediately. puf_trigger drops asynchronously. No partial result is ever presented.
- Synchronisation: raw_response and xor_response pass through 2-flop synchronisers. Only synchronised values are counted.
- Counters:
  - One ones-counter per response bit plus one for xor, each $clog2(NUM_EVALS+1) bits wide.
  - An evaluation index runs 0..NUM_EVALS-1.
- States:
  - IDLE: trigger=0, clear=0. start=1 at a clock edge:
    - latch challenge_in into challenge_out;
    - zero the counters;
    - set busy=1;
    - go to CLEAR.
  - CLEAR: clear=1, trigger=0 for CLEAR_CYCLES cycles, then go to FIRE.
  - FIRE: clear=0, trigger=1 for SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: one cycle, trigger still 1.
    - Add each synchronised bit to its counter.
    - If index=NUM_EVALS-1, go to DONE; otherwise increment index and go to CLEAR.
  - DONE: trigger=0, clear=0.
    - On entry, register results:
      - maj bit = (count >= (NUM_EVALS+1)/2);
      - unstable bit = (count != 0 && count != NUM_EVALS);
      - maj_xor uses the same rule;
      - resp_valid=1.
    - Outputs and resp_valid hold until resp_ready=1 at a clock edge. Then resp_valid=0, busy=0, go to IDLE.
- Latency:
  - resp_valid rises at edge t0 + NUM_EVALS*(CLEAR_CYCLES+SETTLE_CYCLES+1) + 1, where t0 is the accepting edge.
  - Defaults: 166 cycles.
- start handling:
  - Ignored whenever state != IDLE, including in DONE with resp_ready high in the same cycle. The requester must re-assert start in IDLE.
  - challenge_in changes while busy are ignored.
- Boundary conditions:
  - NUM_EVALS=1: maj_response equals the single sample and unstable=0.
  - resp_ready high outside DONE has no effect.

Test Plan:
- PUF model returns constant 6'b101100 and xor=1; start with challenge 64'hDEADBEEF_01234567 -> resp_valid at cycle 166, maj_response=6'b101100, maj_xor=1, unstable=0, challenge_out=64'hDEADBEEF_01234567 throughout.
- Bit0 alternates 1,0,1,… over 15 evals (8 ones), other bits 0 -> maj_response=6'b000001, unstable=6'b000001.
- Bit5 is 1 in exactly 7 evals -> maj_response[5]=0, unstable[5]=1; bit5 at 0 ones -> unstable[5]=0.
- start pulsed and challenge_in changed at cycle 50 of a run -> no restart, challenge_out unchanged, single result at cycle 166.
- resp_ready held low 20 cycles after resp_valid -> resp_valid and outputs stable, busy=1, start ignored. resp_ready=1 -> next cycle resp_valid=0, busy=0.
- reset low during FIRE of eval 3 -> puf_trigger=0 without a clock edge, all outputs 0. After release, a new start yields a full 15-eval result at cycle 166.
